fp_mul_issue: RTL
=================

// Module: fp_mul_issue
// PURPOSE
//  Issue/retire wrapper around the 4-stage fp_multiplier. Accepts FMUL.S ops from decode
//  (valid/ready), drives the multiplier operands, tracks each op through the fixed-latency
//  pipe and captures results into an in-order result FIFO toward FP writeback.
//  Fixes IEEE special cases the multiplier does not handle and produces RISC-V fflags.
// PARAMETERS
//  LATENCY  4  edges from mul_a/mul_b update to valid mul_result (multiplier depth)
//  DEPTH    6  max ops in flight + buffered (credit limit); result FIFO depth; >=1
//  TAG_W    5  destination-register tag width
// PORTS
//  clk         in   1      clock
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      op available
//  in_ready    out  1      op accepted when in_valid&&in_ready at posedge
//  in_a        in   32     operand A (IEEE single)
//  in_b        in   32     operand B
//  in_rd       in   TAG_W  destination tag
//  mul_a       out  32     registered operand A to fp_multiplier
//  mul_b       out  32     registered operand B to fp_multiplier
//  mul_result  in   32     fp_multiplier result
//  out_valid   out  1      FIFO head valid
//  out_ready   in   1      writeback accepts head at posedge
//  out_data    out  32     final product
//  out_rd      out  TAG_W  tag of head
//  out_fflags  out  5      {NV,DZ,OF,UF,NX} of head
// BEHAVIOUR
//  - Reset (reset_n low, any time, incl. mid-op): pipe valid bits, FIFO, credit counter cleared;
//    mul_a/mul_b=0, out_valid=0, in_ready=0 while reset_n low; in_ready=1 first cycle after.
//  - in_ready = (inflight + fifo_count) < DEPTH; combinational from registered counts only.
//  - Issue edge E0: mul_a<=in_a, mul_b<=in_b; slot 0 of LATENCY+1-deep pipe loaded with
//    {valid,rd,class,sign,esum}. No issue: mul_a/mul_b hold, slot 0 valid=0.
//  - Pipe shifts every edge, no stall (multiplier cannot stall; credit guarantees FIFO space).
//  - Slot LATENCY valid in the cycle after edge E0+LATENCY: mul_result sampled, fixed up,
//    pushed to FIFO at next edge. Issue-to-out_valid = LATENCY+1 cycles (5) with empty FIFO.
//  - FIFO: in-order, DEPTH entries, wrapping ptrs; push+pop same edge legal at any occupancy;
//    push when full impossible by credit. Pop on out_valid&&out_ready. out_* from head register.
//  - Credit: +1 on issue, -1 on pop; simultaneous issue+pop leaves count unchanged.
//  - Class at issue per operand: ZERO (exp==0, denorms flushed), INF, QNAN, SNAN, NORM.
//  - esum = ea+eb-127 as 10-bit signed. n=(mul_result[30:23]-esum[7:0]) mod 256, in {0,1};
//    e=esum+n.
//  - Fixup priority (first match):
//    1 either NaN, or INF*ZERO   -> 32'h7FC00000; NV=1 if SNAN present or INF*ZERO
//    2 either INF                -> {s,8'hFF,23'b0}, flags 0 (s = sa^sb)
//    3 either ZERO               -> {s,31'b0}, flags 0
//    4 e>=255                    -> {s,8'hFF,23'b0}, OF=1,NX=1
//    5 e<=0                      -> {s,31'b0}, UF=1,NX=1
//    6 else                      -> mul_result, flags 0 (truncating; NX not tracked). DZ always 0.
// CONFIGURATION
//  FP_MUL_FIXUP_EN defined: class/esum tracking and fixup as above.
//  Not defined: out_data=mul_result unmodified, out_fflags=5'b0; class/esum fields removed
//  from pipe. Ports, latency and handshake identical.
// TESTING
//  - 0x40000000*0x40400000 rd=5, out_ready=1 -> out_valid 5 cycles later, 0x40C00000, rd 5, flags 0
//  - 6 back-to-back issues, out_ready=0 -> in_ready=0 after 6th; out_ready=1 drains all 6 in order
//  - 0x7F800000*0x00000000 -> 0x7FC00000, fflags 5'b10000
//  - 0x7F000000*0x7F000000 -> 0x7F800000, fflags 5'b00101
//  - 0xC0000000*0x00000000 -> 0x80000000, fflags 0; 0x7F800001*0x3F800000 -> 0x7FC00000, 5'b10000
//  - reset_n low 1 cycle with 3 ops in flight -> out_valid stays 0, in_ready=1, no stale output

Source files
------------

// File: rtl/fp_mul_issue.sv
// Purpose: issue/retire wrapper for the 4-stage fp_multiplier with IEEE special-case fixup and fflags.
// Latency: LATENCY+1 cycles from accepted op to out_valid when the result FIFO is empty.
// Backpressure: in_ready drops once in-flight + buffered ops reach DEPTH; out_ready stalls the FIFO head only.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       op handshake from decode; in_a, in_b operands, in_rd destination tag
//   mul_a, mul_b            registered operands to the multiplier (hold when no op issues)
//   mul_result              multiplier output, valid LATENCY edges after mul_a/mul_b update
//   out_valid/out_ready     result handshake toward FP writeback; out_data, out_rd, out_fflags {NV,DZ,OF,UF,NX}
//
// Build option: FP_MUL_FIXUP_EN enables operand classification, exponent tracking and the
// special-case fixup. Without it, out_data is mul_result unmodified and out_fflags is zero.

module fp_mul_issue #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 6,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic [4:0]       out_fflags
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef FP_MUL_FIXUP_EN
    typedef enum logic [2:0] {
        CL_ZERO,
        CL_INF,
        CL_QNAN,
        CL_SNAN,
        CL_NORM
    } cls_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] rd;
        cls_t             cls_a;
        cls_t             cls_b;
        logic             sign;
        logic [9:0]       esum;   // ea+eb-127, two's complement
    } slot_t;

    // Denormals have exp==0 and are flushed to zero.
    function automatic cls_t classify(input logic [31:0] x);
        cls_t c;
        if (x[30:23] == 8'h00)
            c = CL_ZERO;
        else if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0)
                c = CL_INF;
            else if (x[22])
                c = CL_QNAN;
            else
                c = CL_SNAN;
        end else
            c = CL_NORM;
        return c;
    endfunction
`else
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] rd;
    } slot_t;
`endif

    typedef struct packed {
        logic [31:0]      dat;
        logic [TAG_W-1:0] rd;
        logic [4:0]       fflags;
    } res_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Issue
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] credit;
    logic             issue_vld;
    logic             pop_vld;
    logic             push_vld;

    assign in_ready  = reset_n && (credit < CNT_W'(DEPTH));
    assign issue_vld = in_valid && in_ready;

    slot_t slot_in;
    always_comb begin
        slot_in     = '0;
        slot_in.vld = issue_vld;
        slot_in.rd  = in_rd;
`ifdef FP_MUL_FIXUP_EN
        slot_in.cls_a = classify(in_a);
        slot_in.cls_b = classify(in_b);
        slot_in.sign  = in_a[31] ^ in_b[31];
        slot_in.esum  = {2'b00, in_a[30:23]} + {2'b00, in_b[30:23]} - 10'd127;
`endif
    end

    // Tracking pipe mirrors the multiplier depth; slot LATENCY lines up with mul_result.
    slot_t pipe [0:LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a <= 32'd0;
            mul_b <= 32'd0;
            for (int i = 0; i <= LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            if (issue_vld) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            pipe[0] <= slot_in;
            for (int i = 1; i <= LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Fixup of the retiring op
    // ------------------------------------------------------------------
    slot_t tail;
    res_t  push_res;
    assign tail     = pipe[LATENCY];
    assign push_vld = tail.vld;

`ifdef FP_MUL_FIXUP_EN
    logic        nan_any;
    logic        snan_any;
    logic        inf_any;
    logic        zero_any;
    logic        inf_zero;
    logic        n0;
    logic [10:0] e_fin;
`endif

    always_comb begin
        push_res.dat    = mul_result;
        push_res.rd     = tail.rd;
        push_res.fflags = 5'b00000;
`ifdef FP_MUL_FIXUP_EN
        nan_any  = (tail.cls_a == CL_QNAN) || (tail.cls_a == CL_SNAN) ||
                   (tail.cls_b == CL_QNAN) || (tail.cls_b == CL_SNAN);
        snan_any = (tail.cls_a == CL_SNAN) || (tail.cls_b == CL_SNAN);
        inf_any  = (tail.cls_a == CL_INF)  || (tail.cls_b == CL_INF);
        zero_any = (tail.cls_a == CL_ZERO) || (tail.cls_b == CL_ZERO);
        inf_zero = ((tail.cls_a == CL_INF) && (tail.cls_b == CL_ZERO)) ||
                   ((tail.cls_a == CL_ZERO) && (tail.cls_b == CL_INF));
        // The normalisation shift is 0 or 1, so only the LSB of
        // (result exponent - esum) mod 256 matters.
        n0    = mul_result[23] ^ tail.esum[0];
        e_fin = {tail.esum[9], tail.esum} + {10'd0, n0};

        if (nan_any || inf_zero) begin
            push_res.dat       = 32'h7FC00000;
            push_res.fflags[4] = snan_any || inf_zero;
        end else if (inf_any) begin
            push_res.dat = {tail.sign, 8'hFF, 23'd0};
        end else if (zero_any) begin
            push_res.dat = {tail.sign, 31'd0};
        end else if ($signed(e_fin) >= 11'sd255) begin
            push_res.dat    = {tail.sign, 8'hFF, 23'd0};
            push_res.fflags = 5'b00101;
        end else if ($signed(e_fin) <= 11'sd0) begin
            push_res.dat    = {tail.sign, 31'd0};
            push_res.fflags = 5'b00011;
        end
`endif
    end

    // ------------------------------------------------------------------
    // In-order result FIFO and credit counter
    // ------------------------------------------------------------------
    res_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    assign out_valid = (fifo_cnt != '0);
    assign pop_vld   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push_vld)
            mem[wr_ptr] <= push_res;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            credit   <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_vld)
                rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push_vld) - CNT_W'(pop_vld);
            credit   <= credit + CNT_W'(issue_vld) - CNT_W'(pop_vld);
        end
    end

    res_t head;
    assign head       = mem[rd_ptr];
    assign out_data   = head.dat;
    assign out_rd     = head.rd;
    assign out_fflags = head.fflags;

endmodule
